// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with EX-operand forwarding for the 5-stage RV32I
//   core. Holds the decoded instruction for one EX cycle, resolves operand
//   bypass from EX/MEM and MEM/WB, feeds the ALU directly, and flags load-use
//   hazards back to the hazard unit.
//
// Ports
//   clk_i, rst_ni             core clock, async active-low reset
//   stall_i, flush_i          hold contents / insert bubble (flush wins)
//   valid_i ... branch_i      decoded instruction fields from ID
//   exmem_*, memwb_*          forwarding sources from later stages
//   valid_o                   EX holds a real instruction
//   operand_a_o, operand_b_o  ALU operands after forwarding and source select
//   store_data_o              forwarded rs2 (stores, branch compare)
//   pc_o, rd_addr_o, alu_ctrl_o  registered fields
//   reg_write_o ... branch_o  registered controls, gated by valid
//   load_use_hazard_o         ID instruction depends on the load now in EX
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [3:0]            alu_ctrl_i,
    input  logic                  alu_src_a_pc_i,
    input  logic                  alu_src_b_imm_i,
    input  logic                  reg_write_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  branch_i,
    input  logic                  exmem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic [DATA_WIDTH-1:0] exmem_result_i,
    input  logic                  memwb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    input  logic [DATA_WIDTH-1:0] memwb_result_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] operand_a_o,
    output logic [DATA_WIDTH-1:0] operand_b_o,
    output logic [DATA_WIDTH-1:0] store_data_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [3:0]            alu_ctrl_o,
    output logic                  reg_write_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  branch_o,
    output logic                  load_use_hazard_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] rs1_data_q;
    logic [DATA_WIDTH-1:0] rs2_data_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [REG_ADDR_W-1:0] rs1_addr_q;
    logic [REG_ADDR_W-1:0] rs2_addr_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [3:0]            alu_ctrl_q;
    logic                  src_a_pc_q;
    logic                  src_b_imm_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  branch_q;

    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    // Flush only needs to kill valid and the side-effecting controls; the
    // datapath fields simply hold, since nothing downstream consumes them
    // while valid is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_q        <= '0;
            alu_ctrl_q  <= 4'b0000;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end else if (flush_i) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end else if (!stall_i) begin
            valid_q     <= valid_i;
            pc_q        <= pc_i;
            rs1_data_q  <= rs1_data_i;
            rs2_data_q  <= rs2_data_i;
            imm_q       <= imm_i;
            rs1_addr_q  <= rs1_addr_i;
            rs2_addr_q  <= rs2_addr_i;
            rd_q        <= rd_addr_i;
            alu_ctrl_q  <= alu_ctrl_i;
            src_a_pc_q  <= alu_src_a_pc_i;
            src_b_imm_q <= alu_src_b_imm_i;
            reg_write_q <= reg_write_i;
            mem_read_q  <= mem_read_i;
            mem_write_q <= mem_write_i;
            branch_q    <= branch_i;
        end
    end

    // EX/MEM is checked first because it holds the younger result. x0 never
    // forwards, so it always reads the (zero) register-file value.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_reg_write_i && (exmem_rd_i == rs1_addr_q) && (rs1_addr_q != '0))
            fwd_rs1 = exmem_result_i;
        else if (memwb_reg_write_i && (memwb_rd_i == rs1_addr_q) && (rs1_addr_q != '0))
            fwd_rs1 = memwb_result_i;
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (exmem_reg_write_i && (exmem_rd_i == rs2_addr_q) && (rs2_addr_q != '0))
            fwd_rs2 = exmem_result_i;
        else if (memwb_reg_write_i && (memwb_rd_i == rs2_addr_q) && (rs2_addr_q != '0))
            fwd_rs2 = memwb_result_i;
    end

    assign operand_a_o  = src_a_pc_q  ? pc_q  : fwd_rs1;
    assign operand_b_o  = src_b_imm_q ? imm_q : fwd_rs2;
    assign store_data_o = fwd_rs2;

    assign valid_o     = valid_q;
    assign pc_o        = pc_q;
    assign rd_addr_o   = rd_q;
    assign alu_ctrl_o  = alu_ctrl_q;
    assign reg_write_o = reg_write_q & valid_q;
    assign mem_read_o  = mem_read_q  & valid_q;
    assign mem_write_o = mem_write_q & valid_q;
    assign branch_o    = branch_q    & valid_q;

    // rs2 is compared even for I-type instructions; the occasional spurious
    // stall is cheaper than decoding the format here.
    assign load_use_hazard_o = valid_q & mem_read_q & (rd_q != '0) & valid_i
                             & ((rd_q == rs1_addr_i) | (rd_q == rs2_addr_i));

endmodule
